beat_note_scheduler: RTL
========================

Name: beat_note_scheduler

Overview:
- Downstream consumer of the beatmap data generator.
- Accepts the generator's data_en/data note-code stream and validates each code against the lane map.
- Buffers valid codes in a small FIFO and releases one note per beat tick to the gameplay/display stage with a valid/ready handshake.
- Flags dropped, invalid and missed notes.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
BEAT_CYCLES, 12500000, clk cycles per beat (>=2)
LANE_BASE, 80, note code mapped to lane 0
LANE_SHIFT, 2, log2 of code spacing between lanes (step 4)
NUM_LANES, 5, number of valid lanes (codes 80,84,88,92,96 by default)

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
run  input  1  beat timer enable; 0 holds timer at 0
data_en  input  1  input code qualifier from generator
data  input  8  note code from generator
note_ready  input  1  display stage accepts presented note
note_valid  output  1  note presented
note_lane  output  3  lane index of presented note
note_code  output  8  raw code of presented note
beat_tick  output  1  one-cycle pulse at each beat boundary
miss_pulse  output  1  one-cycle pulse when a presented note expires unaccepted
err_pulse  output  1  one-cycle pulse when an input code is rejected as invalid
drop_cnt  output  8  saturating count of valid codes lost to FIFO full
fifo_count  output  4  current FIFO occupancy (0..DEPTH)

Behaviour:
- Reset is asynchronous, active-low, and applies at any time including mid-beat or mid-handshake.
  - Reset values: all outputs 0, FIFO emptied, timer 0, FSM IDLE.
- Input validation, combinational on data:
  - Valid iff data >= LANE_BASE, (data-LANE_BASE) has LANE_SHIFT low bits zero, and (data-LANE_BASE)>>LANE_SHIFT < NUM_LANES.
  - Lane = (data-LANE_BASE)>>LANE_SHIFT, stored with the code.
  - Invalid code with data_en=1: not written; err_pulse=1 on the next cycle.
- FIFO write:
  - Occurs when data_en=1, the code is valid, and (fifo_count<DEPTH or a pop occurs the same cycle).
  - A valid code arriving while full with no pop is dropped; drop_cnt increments and saturates at 255.
  - Simultaneous push and pop leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- Beat timer:
  - When run=1, counts 0..BEAT_CYCLES-1 and wraps.
  - beat_tick=1 in the cycle the counter equals BEAT_CYCLES-1.
  - When run=0: counter forced to 0 and beat_tick=0.
  - Deasserting run does not clear the FIFO or a presented note.
- Output FSM:
  - IDLE: no note presented.
    - On beat_tick with fifo_count>0: pop head; next cycle note_valid=1 with note_code/note_lane registered; go PRESENT.
    - On beat_tick with fifo_count=0: stay IDLE.
  - PRESENT: note_valid=1; note_code and note_lane stable until handshake.
    - note_valid&note_ready in a cycle completes the note; next cycle note_valid=0; go IDLE.
    - beat_tick while still unaccepted, with no handshake that cycle:
      - Note expires; miss_pulse=1 next cycle.
      - If FIFO non-empty: pop the next note, which is presented from the next cycle (stay PRESENT).
      - Otherwise: note_valid=0; go IDLE.
    - Handshake and beat_tick in the same cycle: the note counts as accepted (no miss).
      - If FIFO non-empty: next note popped and presented next cycle (stay PRESENT).
      - Otherwise: go IDLE.
- At most one pop per cycle. A pop decision uses the fifo_count from before any same-cycle write, so a note written in a cycle cannot be presented in that cycle.
- Latency: beat_tick at cycle T results in note_valid at T+1.
- Throughput: at most one note per beat.

Test Plan:
- Reset, then stream: BEAT_CYCLES=8, DEPTH=4, run=1; generator pattern 80,84,88,92,96 with data_en=1 every cycle.
  - FIFO fills to 4 and further codes increment drop_cnt.
  - note_ready=1: notes appear one cycle after each beat_tick, lanes 0,1,2,3 in order.
- Invalid codes: data=81, then 100, then 76 with data_en=1.
  - err_pulse on each; fifo_count stays 0; drop_cnt unchanged.
- Miss handling: FIFO holds 84,88 with note_ready=0.
  - First beat presents 84 (lane 1).
  - Next beat: miss_pulse=1 and 88 (lane 2) is presented.
  - Third beat: miss_pulse=1, then note_valid=0 and FSM IDLE.
- Simultaneous events: assert note_ready exactly in a beat_tick cycle with 92 queued.
  - No miss_pulse; 92 (lane 3) presented next cycle.
  - With FIFO full and a pop in the same cycle as a write, fifo_count stays 4 and drop_cnt is unchanged.
- Run gating and reset: run=0 for 20 cycles.
  - No beat_tick; presented note held.
  - Then assert resetn=0 mid-PRESENT: all outputs 0 immediately and fifo_count=0.
  - After release, the first beat_tick occurs BEAT_CYCLES cycles after run=1.
- Saturation: hold the FIFO full with a valid code and data_en=1 for 300 cycles.
  - drop_cnt stops at 255.

Source files
------------

// File: rtl/beat_note_scheduler.sv
// beat_note_scheduler: validates generator note codes against the lane map,
// queues them in a small FIFO and releases at most one note per beat tick.
// Handshake: a note transfers in any cycle where note_valid && note_ready are
// both high; note_valid never drops and note_code/note_lane never change while
// a note waits, except when a beat tick expires it.
module beat_note_scheduler #(
   parameter int DEPTH       = 8,
   parameter int BEAT_CYCLES = 12500000,
   parameter int LANE_BASE   = 80,
   parameter int LANE_SHIFT  = 2,
   parameter int NUM_LANES   = 5
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       run,
   input  logic       data_en,
   input  logic [7:0] data,
   input  logic       note_ready,
   output logic       note_valid,
   output logic [2:0] note_lane,
   output logic [7:0] note_code,
   output logic       beat_tick,
   output logic       miss_pulse,
   output logic       err_pulse,
   output logic [7:0] drop_cnt,
   output logic [3:0] fifo_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] LAST_TICK = TW'(BEAT_CYCLES - 1);
   localparam logic [7:0]    BASE      = 8'(LANE_BASE);
   localparam logic [7:0]    STEP_MASK = 8'((1 << LANE_SHIFT) - 1);
   localparam logic [7:0]    LANES     = 8'(NUM_LANES);

   // note_valid is the FSM state seen from outside: PRESENT <=> note_valid
   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   beat_cnt;
   logic [7:0]      offset, lane_idx;
   logic            code_ok, push, pop, drop;
   logic [10:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;

   // lane decode: code must sit on the lane grid starting at LANE_BASE
   assign offset   = data - BASE;
   assign lane_idx = offset >> LANE_SHIFT;
   assign code_ok  = (data >= BASE) && ((offset & STEP_MASK) == 8'd0) && (lane_idx < LANES);

   // pop decision looks only at occupancy before this cycle's write
   assign pop  = beat_tick && (count != '0);
   assign push = data_en && code_ok && ((count != FULL_LVL) || pop);
   assign drop = data_en && code_ok && (count == FULL_LVL) && !pop;

   assign beat_tick  = run && (beat_cnt == LAST_TICK);
   assign fifo_count = 4'(count);

   // beat timer: free-running while run is high, parked at zero otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                    beat_cnt <= '0;
      else if (!run)                  beat_cnt <= '0;
      else if (beat_cnt == LAST_TICK) beat_cnt <= '0;
      else                            beat_cnt <= beat_cnt + 1'b1;
   end

   // FIFO storage: {lane, code} per entry, no reset needed on the array
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {lane_idx[2:0], data};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // status pulses and saturating drop counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         drop_cnt   <= 8'd0;
      end else begin
         err_pulse  <= data_en && !code_ok;
         miss_pulse <= (state_q == PRESENT) && beat_tick && !note_ready;
         if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // presented note payload is loaded only by a pop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         note_lane <= 3'd0;
         note_code <= 8'd0;
      end else if (pop) begin
         {note_lane, note_code} <= mem[rd_ptr];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: a pop always (re)presents; handshake or expiry retires
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = PRESENT;
         PRESENT: begin
            if (pop)                          state_d = PRESENT;
            else if (note_ready || beat_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      note_valid = (state_q == PRESENT);
   end

endmodule
